// File: rtl/fetch_pkg.sv
// Shared fetch definitions: address/data widths, the halt encoding (also
// used by decode) and the sequencer state type.
package fetch_pkg;

  localparam int unsigned FETCH_AW = 6;
  localparam int unsigned FETCH_DW = 16;

  // Encoding that stops instruction fetch once it has been loaded.
  localparam logic [FETCH_DW-1:0] FETCH_HALT_INSTR = 16'hF000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer for the program ROM.
// Owns the PC (driven straight out as the ROM address), captures the
// combinational ROM data into a single valid/ready output stage toward
// decode, and handles redirects, halt detection and run/idle control.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   run               level, enables fetching
//   redirect_valid    one-cycle pulse: load redirect_pc, flush output stage
//   redirect_pc       redirect target
//   rom_pc            ROM address (the PC register)
//   rom_instr         ROM data for rom_pc, same cycle
//   dec_valid/ready   output-stage handshake toward decode
//   dec_instr/dec_pc  instruction held in the output stage and its address
//   halted            sequencer is in HALT
//   fetch_count       instructions delivered to decode, saturating
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned    AW         = FETCH_AW,
  parameter int unsigned    DW         = FETCH_DW,
  parameter logic [AW-1:0]  RESET_PC   = '0,
  parameter logic [DW-1:0]  HALT_INSTR = DW'(FETCH_HALT_INSTR)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] rom_pc,
  input  logic [DW-1:0] rom_instr,
  output logic          dec_valid,
  input  logic          dec_ready,
  output logic [DW-1:0] dec_instr,
  output logic [AW-1:0] dec_pc,
  output logic          halted,
  output logic [15:0]   fetch_count
);

  localparam int unsigned CW = 16;

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          dec_valid_q, dec_valid_d;
  logic [DW-1:0] dec_instr_q, dec_instr_d;
  logic [AW-1:0] dec_pc_q, dec_pc_d;
  logic          halted_q, halted_d;
  logic [CW-1:0] fetch_count_q, fetch_count_d;

  logic take_c;
  logic load_c;
  logic is_halt_c;

  // State and output-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      dec_valid_q   <= 1'b0;
      dec_instr_q   <= '0;
      dec_pc_q      <= '0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      dec_valid_q   <= dec_valid_d;
      dec_instr_q   <= dec_instr_d;
      dec_pc_q      <= dec_pc_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next-state, PC, output-stage and counter logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    dec_valid_d   = dec_valid_q;
    dec_instr_d   = dec_instr_q;
    dec_pc_d      = dec_pc_q;
    fetch_count_d = fetch_count_q;

    take_c    = dec_valid_q & dec_ready;
    // The stage can accept a new word when empty or draining this cycle.
    load_c    = (state_q == RUN) & run & ~redirect_valid & (~dec_valid_q | dec_ready);
    is_halt_c = (rom_instr == HALT_INSTR);

    // Deliveries count in every state, including a redirect cycle.
    if (take_c && (fetch_count_q != {CW{1'b1}})) begin
      fetch_count_d = fetch_count_q + CW'(1);
    end

    if (redirect_valid) begin
      // Redirect wins over everything: flush and restart at the target.
      pc_d        = redirect_pc;
      dec_valid_d = 1'b0;
      state_d     = RUN;
    end else begin
      unique case (state_q)
        IDLE:    if (run)  state_d = RUN;
        RUN:     if (!run) state_d = IDLE;
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase

      if (load_c) begin
        dec_valid_d = 1'b1;
        dec_instr_d = rom_instr;
        dec_pc_d    = pc_q;
        // Halt word is delivered, but the PC parks on it.
        if (is_halt_c) begin
          state_d = HALT;
        end else begin
          pc_d = pc_q + AW'(1);
        end
      end else if (take_c) begin
        dec_valid_d = 1'b0;
      end
    end

    halted_d = (state_d == HALT);
  end

  assign rom_pc      = pc_q;
  assign dec_valid   = dec_valid_q;
  assign dec_instr   = dec_instr_q;
  assign dec_pc      = dec_pc_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule : fetch_sequencer
